// File: rtl/id_exe_stage_reg_pkg.sv
// Shared encodings and bus layouts for the ID/EXE pipeline register.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package id_exe_stage_reg_pkg;

    // ALU commands produced by the control unit
    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Instruction class field of the encoding
    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10
    } mode_e;

    // Bit positions inside the 4-bit NZCV status word
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Control bus carried across the stage boundary
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Data bus bits that do not scale with DATA_W:
    // imm(1) + shift_operand(12) + signed_imm_24(24) + dest/src1/src2(12) + status(4)
    localparam int DATA_FIXED_W = 1 + 12 + 24 + 4 + 4 + 4 + 4;

endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// Generic WIDTH-bit pipeline register with hold enable and synchronous clear.
// Latency: 1 cycle from d_i to q_o.
// Backpressure: en_i=0 holds q_o unconditionally; clear only acts when enabled.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Hold dominates; when advancing, clear dominates load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                data_q <= '0;
            end else begin
                data_q <= d_i;
            end
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze/flush and stall/squash performance counters.
// Latency: 1 cycle, every output is a flop output.
// Backpressure: freeze holds all fields (and beats flush); flush loads a NOP.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              clear_counters,

    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic              id_imm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic [3:0]        id_status,

    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_b,
    output logic              exe_s,
    output logic [3:0]        exe_exe_cmd,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic              exe_imm,
    output logic [11:0]       exe_shift_operand,
    output logic [23:0]       exe_signed_imm_24,
    output logic [3:0]        exe_dest,
    output logic [3:0]        exe_src1,
    output logic [3:0]        exe_src2,
    output logic [3:0]        exe_status,

    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int DBUS_W = 3 * DATA_W + DATA_FIXED_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;
    logic [DBUS_W-1:0] data_d;
    logic [DBUS_W-1:0] data_q;

    // A flush squashes the whole entry, so both buses share enable and clear
    logic              adv;

    logic [CNT_W-1:0]  stall_d;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  bubble_d;
    logic [CNT_W-1:0]  bubble_q;

    assign adv = ~freeze;

    // Pack the control-unit outputs into the control bus
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.valid    = id_valid;
        ctrl_d.wb_en    = id_wb_en;
        ctrl_d.mem_r_en = id_mem_r_en;
        ctrl_d.mem_w_en = id_mem_w_en;
        ctrl_d.b        = id_b;
        ctrl_d.s        = id_s;
        ctrl_d.exe_cmd  = id_exe_cmd;
    end

    assign data_d = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
                     id_signed_imm_24, id_dest, id_src1, id_src2, id_status};

    pipe_reg #(
        .WIDTH (CTRL_W)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv),
        .clr_i (flush),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    pipe_reg #(
        .WIDTH (DBUS_W)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv),
        .clr_i (flush),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    assign exe_valid    = ctrl_q.valid;
    assign exe_wb_en    = ctrl_q.wb_en;
    assign exe_mem_r_en = ctrl_q.mem_r_en;
    assign exe_mem_w_en = ctrl_q.mem_w_en;
    assign exe_b        = ctrl_q.b;
    assign exe_s        = ctrl_q.s;
    assign exe_exe_cmd  = ctrl_q.exe_cmd;

    assign {exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
            exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_status} = data_q;

    // Stall counter next state: clear wins, otherwise saturating count of frozen cycles
    always_comb begin
        stall_d = stall_q;
        if (clear_counters) begin
            stall_d = '0;
        end else if (freeze && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    // Squash counter next state: only a real instruction actually dropped by a flush counts
    always_comb begin
        bubble_d = bubble_q;
        if (clear_counters) begin
            bubble_d = '0;
        end else if (flush && !freeze && id_valid && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_ONE;
        end
    end

    // Counter state, reset asynchronously with the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_count  = stall_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios then randomized traffic.
// Latency: outputs compared half a cycle after each rising edge.
// Backpressure: freeze/flush/clear driven both directed and at random.
module tb_id_exe_stage_reg;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int BW   = 10 + 3 * DW + 53;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, freeze, flush, clear_counters;
    logic          id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
    logic [3:0]    id_exe_cmd;
    logic [DW-1:0] id_pc, id_val_rn, id_val_rm;
    logic          id_imm;
    logic [11:0]   id_shift_operand;
    logic [23:0]   id_signed_imm_24;
    logic [3:0]    id_dest, id_src1, id_src2, id_status;

    logic          exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s;
    logic [3:0]    exe_exe_cmd;
    logic [DW-1:0] exe_pc, exe_val_rn, exe_val_rm;
    logic          exe_imm;
    logic [11:0]   exe_shift_operand;
    logic [23:0]   exe_signed_imm_24;
    logic [3:0]    exe_dest, exe_src1, exe_src2, exe_status;
    logic [CW-1:0] stall_count, bubble_count;

    id_exe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .clear_counters(clear_counters),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_status(id_status),
        .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b), .exe_s(exe_s),
        .exe_exe_cmd(exe_exe_cmd), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn),
        .exe_val_rm(exe_val_rm), .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
        .exe_signed_imm_24(exe_signed_imm_24), .exe_dest(exe_dest), .exe_src1(exe_src1),
        .exe_src2(exe_src2), .exe_status(exe_status),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the EXE side should show, and the two event tallies
    logic [BW-1:0] m_bus;
    int            m_stall;
    int            m_bubble;

    function automatic logic [BW-1:0] id_bus();
        return {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_exe_cmd,
                id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand, id_signed_imm_24,
                id_dest, id_src1, id_src2, id_status};
    endfunction

    function automatic logic [BW-1:0] exe_bus();
        return {exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_exe_cmd,
                exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand, exe_signed_imm_24,
                exe_dest, exe_src1, exe_src2, exe_status};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_bus"},    256'(exe_bus()),    256'(m_bus));
        check({tag, "_stall"},  256'(stall_count),  256'(m_stall));
        check({tag, "_bubble"}, 256'(bubble_count), 256'(m_bubble));
    endtask

    task automatic model_reset();
        m_bus    = '0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    // One clock: apply the stage rules to the model at the edge, compare mid-cycle
    task automatic step(input string tag);
        @(posedge clk);
        if (clear_counters) m_stall = 0;
        else if (freeze) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (clear_counters) m_bubble = 0;
        else if (flush && !freeze && id_valid) m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
        if (!freeze) m_bus = flush ? '0 : id_bus();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic zero_inputs();
        {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s} = '0;
        id_exe_cmd = '0; id_pc = '0; id_val_rn = '0; id_val_rm = '0; id_imm = 1'b0;
        id_shift_operand = '0; id_signed_imm_24 = '0;
        id_dest = '0; id_src1 = '0; id_src2 = '0; id_status = '0;
    endtask

    task automatic drive_add();
        zero_inputs();
        id_exe_cmd = 4'b0010; id_wb_en = 1'b1; id_val_rn = 32'h5; id_dest = 4'h3; id_valid = 1'b1;
    endtask

    task automatic drive_rand();
        id_valid = 1'($urandom); id_wb_en = 1'($urandom); id_mem_r_en = 1'($urandom);
        id_mem_w_en = 1'($urandom); id_b = 1'($urandom); id_s = 1'($urandom);
        id_exe_cmd = 4'($urandom_range(0, 9));
        id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom; id_imm = 1'($urandom);
        id_shift_operand = 12'($urandom); id_signed_imm_24 = 24'($urandom);
        id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
        id_status = 4'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; clear_counters = 1'b0;
        zero_inputs();
        model_reset();

        // Reset state
        drive_rand();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset_cmd", 256'(exe_exe_cmd), 256'(4'b0000));
        rst_n = 1'b1;

        // Reset then load ADD
        drive_add();
        step("load_add");
        check("load_cmd",   256'(exe_exe_cmd), 256'(4'b0010));
        check("load_wb",    256'(exe_wb_en),   256'(1'b1));
        check("load_rn",    256'(exe_val_rn),  256'(32'h5));
        check("load_dest",  256'(exe_dest),    256'(4'h3));
        check("load_valid", 256'(exe_valid),   256'(1'b1));

        // Freeze holds ADD while SUB waits in ID
        freeze = 1'b1; id_exe_cmd = 4'b0100; id_val_rn = 32'h77;
        for (int i = 0; i < 3; i++) begin
            step("freeze_hold");
            check("freeze_cmd", 256'(exe_exe_cmd), 256'(4'b0010));
        end
        check("freeze_stall3", 256'(stall_count), 256'(3));
        freeze = 1'b0;

        // Flush squashes a valid store
        flush = 1'b1; id_valid = 1'b1; id_mem_w_en = 1'b1; id_val_rm = 32'hDEAD_BEEF;
        step("flush");
        check("flush_memw",   256'(exe_mem_w_en), 256'(1'b0));
        check("flush_cmd",    256'(exe_exe_cmd),  256'(4'b0000));
        check("flush_rm",     256'(exe_val_rm),   256'(0));
        check("flush_bubble", 256'(bubble_count), 256'(1));
        flush = 1'b0;

        // Freeze beats flush, then flush applies on the first unfrozen edge
        drive_add(); clear_counters = 1'b1;
        step("reload_clear");
        clear_counters = 1'b0;
        freeze = 1'b1; flush = 1'b1; id_exe_cmd = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            step("frz_flush");
            check("frz_flush_cmd", 256'(exe_exe_cmd), 256'(4'b0010));
        end
        freeze = 1'b0;
        step("flush_after_frz");
        check("faf_cmd",    256'(exe_exe_cmd),  256'(4'b0000));
        check("faf_stall",  256'(stall_count),  256'(2));
        check("faf_bubble", 256'(bubble_count), 256'(1));
        flush = 1'b0;

        // Saturation of the stall counter and clear under freeze
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) step("saturate");
        check("sat_stall", 256'(stall_count), 256'(4'hF));
        clear_counters = 1'b1;
        step("clear_frozen");
        check("clear_stall", 256'(stall_count), 256'(0));
        clear_counters = 1'b0; freeze = 1'b0;

        // Asynchronous reset between edges
        drive_rand(); id_valid = 1'b1; flush = 1'b0;
        step("pre_arst");
        check("pre_arst_valid", 256'(exe_valid), 256'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst_now");
        @(posedge clk);
        #1 check_all("arst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive_rand();
            freeze         = ($urandom_range(0, 99) < 25);
            flush          = ($urandom_range(0, 99) < 20);
            clear_counters = ($urandom_range(0, 99) < 4);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Pipeline register between the ID stage (control unit, register file, immediate fields) and the EXE stage (ALU, branch, status update) of the ARM pipeline. It captures every ID-stage control and data field on each clock edge. It supports a global freeze (hazard or memory stall) and a flush (taken branch in EXE), and counts stall cycles and squashed instructions for performance measurement.

## Interface
- DATA_W, 32, width of PC and register operands
- CNT_W, 16, width of each performance counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- freeze  in  1  hold all state this cycle
- flush  in  1  squash the instruction being captured
- clear_counters  in  1  synchronous clear of both performance counters
- id_valid  in  1  ID holds a real instruction
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  in  1 each  control-unit outputs
- id_exe_cmd  in  4  ALU command from the control unit
- id_pc  in  DATA_W  PC+4 of the instruction
- id_val_rn, id_val_rm  in  DATA_W  register-file read data
- id_imm  in  1  I bit
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_dest, id_src1, id_src2  in  4 each  destination and source register numbers
- id_status  in  4  NZCV from the status register
- exe_* outputs  out  same widths  registered copies of every id_* input above, including exe_valid
- stall_count  out  CNT_W  cycles with freeze=1
- bubble_count  out  CNT_W  valid instructions squashed by flush

## Operation
- Reset (rst_n=0, asynchronous): every exe_* output is 0 and exe_exe_cmd is 4'b0000 (NOP). Both counters are 0. Reset asserted mid-operation takes effect immediately, regardless of freeze or flush.
- Per rising edge, the pipeline fields follow this priority order:
  - freeze=1: all exe_* fields hold. Freeze has priority over flush. The branch in EXE is also frozen and re-asserts flush on the first unfrozen cycle.
  - flush=1 (freeze=0): exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b and exe_s go to 0. exe_exe_cmd goes to 4'b0000. All data and register-number fields go to 0.
  - otherwise: every exe_* field loads its id_* counterpart.
- A bubble (id_valid=0, no flush) loads normally. The control unit already drives zero enables for it; no extra masking is applied.
- stall_count:
  - clear_counters=1 sets it to 0. This has priority over increment and works regardless of freeze.
  - else it increments when freeze=1.
  - It saturates at all-ones with no wrap.
- bubble_count:
  - clear_counters=1 sets it to 0, with the same priority as above.
  - else it increments when flush=1, freeze=0 and id_valid=1.
  - It saturates at all-ones.
- Counters are independent of pipeline state. A simultaneous clear and increment yields 0.

## Timing
- Latency is 1 cycle: id_* sampled at edge N appears on exe_* after edge N.
- No combinational path from any input to any output. All outputs are register outputs.
- freeze and flush are sampled at the same edge as the data. A flush asserted in cycle N produces a NOP on exe_* from edge N onward.
- Back-to-back freeze cycles hold exe_* indefinitely. The first cycle with freeze=0 applies flush or load as above.

## Structure
- Shared package/include holds:
  - exe_cmd encodings: NOP 0000, MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001
  - mode encodings: data-processing 00, memory 01, branch 10
  - NZCV bit indices
- One sub-module: pipe_reg, a parameterized WIDTH register with async active-low reset, enable (=~freeze), synchronous clear (=flush) and clear-over-load priority. It is instantiated once on the concatenated control bus and once on the concatenated data bus.
- Counters live in the top module as two saturating increment processes.

## Test plan
- Reset then load: rst_n low, then release. Drive id_exe_cmd=0010, id_wb_en=1, id_val_rn=32'h5, id_dest=4'h3, id_valid=1. One edge later: exe_exe_cmd=0010, exe_wb_en=1, exe_val_rn=5, exe_dest=3, exe_valid=1.
- Freeze hold: load ADD as above, then freeze=1 for 3 cycles while id_* changes to SUB. Required: exe_* stays ADD for all 3 cycles, and stall_count=3.
- Flush: flush=1 with id_valid=1, id_mem_w_en=1. Next edge: all exe control bits 0, exe_exe_cmd=0000, exe_val_rm=0, bubble_count=1.
- Freeze and flush together: both high for 2 cycles, then flush only for 1 cycle. Required: exe_* held for the 2 cycles, then NOP; stall_count=2, bubble_count=1.
- Counter saturation and clear: CNT_W=4, hold freeze for 20 cycles. Required: stall_count reaches 4'hF and stays there. Then assert clear_counters with freeze=1: stall_count=0 on the next edge.
- Async reset mid-stream: pull rst_n low between edges while exe_valid=1. Required: all outputs 0 before the next clock edge.
